// File: rtl/pooling_layer_mc.sv
`default_nettype none
// ============================================================================
// pooling_layer_mc : streaming multi-channel N x N max/average pooling layer
// Revision: 1.0
// ============================================================================
module pooling_layer_mc #(
  parameter int BitSize     = 4,
  parameter int N           = 2,
  parameter int ImageWidth  = 6,
  parameter int Stride      = 2,
  parameter int NumChannels = 1,
  parameter int Mode        = 0
) (
  input  logic                           clk,
  input  logic                           res,
  input  logic                           in_valid,
  input  logic [NumChannels*BitSize-1:0] in_data,
  output logic                           out_ready,
  output logic                           out_valid,
  output logic [NumChannels*BitSize-1:0] out_data,
  input  logic                           next_ready,
  output logic                           out_last
);

  localparam int LOG2N = $clog2(N);
  localparam int SH    = 2 * LOG2N;
  localparam int SUMW  = BitSize + SH;
  localparam int CW    = (ImageWidth > 1) ? $clog2(ImageWidth) : 1;
  localparam int PW    = (Stride > 1) ? $clog2(Stride) : 1;
  localparam logic [CW-1:0] POS_LAST  = CW'(ImageWidth - 1);
  localparam logic [CW-1:0] POS_FIRST = CW'(N - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(Stride - 1);

  typedef logic signed [BitSize-1:0] samp_t;

  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic [PW-1:0] col_ph_q, col_ph_d, row_ph_q, row_ph_d;
  samp_t lb_q  [N-1][ImageWidth][NumChannels];
  samp_t lb_d  [N-1][ImageWidth][NumChannels];
  samp_t win_q [N][N-1][NumChannels];
  samp_t win_d [N][N-1][NumChannels];
  samp_t full_w [N][N][NumChannels];
  samp_t pool_w [NumChannels];
  samp_t mx;
  logic signed [SUMW-1:0] acc;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [NumChannels*BitSize-1:0] out_data_q, out_data_d;
  logic xfer_in, win_done, frame_end;

  assign out_ready = !(out_valid_q && !next_ready);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign xfer_in   = in_valid && out_ready;
  // Phase counters track (pos-N+1) % Stride so no divider is needed.
  assign win_done  = xfer_in && (row_q >= POS_FIRST) && (col_q >= POS_FIRST) &&
                     (row_ph_q == '0) && (col_ph_q == '0);
  assign frame_end = (row_q == POS_LAST) && (col_q == POS_LAST);

  // Column 0 is the incoming column (oldest row first); columns 1.. come from win_q.
  always_comb begin
    for (int ch = 0; ch < NumChannels; ch++) begin
      for (int i = 0; i < N; i++) begin
        if (i == N - 1) full_w[i][0][ch] = samp_t'(in_data[ch*BitSize +: BitSize]);
        else            full_w[i][0][ch] = lb_q[N-2-i][col_q][ch];
        for (int j = 0; j < N - 1; j++) full_w[i][j+1][ch] = win_q[i][j][ch];
      end
    end
  end

  always_comb begin
    mx  = '0;
    acc = '0;
    for (int ch = 0; ch < NumChannels; ch++) begin
      mx  = full_w[0][0][ch];
      acc = '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (full_w[i][j][ch] > mx) mx = full_w[i][j][ch];
          acc = acc + SUMW'(full_w[i][j][ch]);
        end
      end
      pool_w[ch] = (Mode != 0) ? BitSize'(acc >>> SH) : mx;
    end
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    col_ph_d    = col_ph_q;
    row_ph_d    = row_ph_q;
    lb_d        = lb_q;
    win_d       = win_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (xfer_in) begin
      for (int ch = 0; ch < NumChannels; ch++) begin
        for (int a = 0; a < N - 1; a++) lb_d[a][col_q][ch] = full_w[N-1-a][0][ch];
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N - 1; j++) win_d[i][j][ch] = full_w[i][j][ch];
      end
      if (col_q == POS_LAST) begin
        col_d    = '0;
        col_ph_d = '0;
        if (row_q == POS_LAST) begin
          row_d    = '0;
          row_ph_d = '0;
        end else begin
          row_d    = row_q + CW'(1);
          row_ph_d = (row_q < POS_FIRST || row_ph_q == PH_LAST) ? '0 : row_ph_q + PW'(1);
        end
      end else begin
        col_d    = col_q + CW'(1);
        col_ph_d = (col_q < POS_FIRST || col_ph_q == PH_LAST) ? '0 : col_ph_q + PW'(1);
      end
    end
    if (win_done) begin
      out_valid_d = 1'b1;
      out_last_d  = frame_end;
      for (int ch = 0; ch < NumChannels; ch++) out_data_d[ch*BitSize +: BitSize] = pool_w[ch];
    end else if (out_valid_q && next_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      col_q       <= '0;
      row_q       <= '0;
      col_ph_q    <= '0;
      row_ph_q    <= '0;
      lb_q        <= '{default: '0};
      win_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      col_ph_q    <= col_ph_d;
      row_ph_q    <= row_ph_d;
      lb_q        <= lb_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pooling_layer_mc.sv
`default_nettype none
// ============================================================================
// tb_pooling_layer_mc : directed checks of max/avg pooling, stride, backpressure
// Revision: 1.0
// ============================================================================
module tb_pooling_layer_mc;

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int nout  = 0;
  int nlast = 0;

  // A: max, stride 2; B: avg, 2 channels; C: max, stride 1
  logic       a_iv, a_or, a_ov, a_nr, a_ol;
  logic [3:0] a_id, a_od;
  logic       b_iv, b_or, b_ov, b_nr, b_ol;
  logic [7:0] b_id, b_od;
  logic       c_iv, c_or, c_ov, c_nr, c_ol;
  logic [3:0] c_id, c_od;

  pooling_layer_mc dut_a (
    .clk(clk), .res(res), .in_valid(a_iv), .in_data(a_id), .out_ready(a_or),
    .out_valid(a_ov), .out_data(a_od), .next_ready(a_nr), .out_last(a_ol));

  pooling_layer_mc #(.Mode(1), .NumChannels(2)) dut_b (
    .clk(clk), .res(res), .in_valid(b_iv), .in_data(b_id), .out_ready(b_or),
    .out_valid(b_ov), .out_data(b_od), .next_ready(b_nr), .out_last(b_ol));

  pooling_layer_mc #(.Stride(1)) dut_c (
    .clk(clk), .res(res), .in_valid(c_iv), .in_data(c_id), .out_ready(c_or),
    .out_valid(c_ov), .out_data(c_od), .next_ready(c_nr), .out_last(c_ol));

  logic [3:0] img [6][6] = '{
    '{4'h7, 4'h2, 4'h2, 4'hF, 4'h2, 4'hF},
    '{4'h8, 4'h8, 4'hF, 4'h7, 4'hF, 4'h7},
    '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5},
    '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA},
    '{4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8},
    '{4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h9}};
  logic [3:0] exp_max [9] = '{4'h7, 4'h7, 4'h7, 4'h1, 4'h3, 4'h5, 4'h8, 4'h8, 4'h9};
  logic [3:0] exp_avg [9] = '{4'hE, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 4'h8, 4'h8, 4'h8};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic bit done2(input int r, input int c, input int s);
    return (r >= 1) && (c >= 1) && ((r - 1) % s == 0) && ((c - 1) % s == 0);
  endfunction

  function automatic logic [3:0] pv(input int r, input int c);
    return 4'(r * 6 + c);
  endfunction

  function automatic logic [3:0] maxc(input int r, input int c);
    logic signed [3:0] m;
    m = $signed(pv(r - 1, c - 1));
    if ($signed(pv(r - 1, c)) > m) m = $signed(pv(r - 1, c));
    if ($signed(pv(r, c - 1)) > m) m = $signed(pv(r, c - 1));
    if ($signed(pv(r, c)) > m)     m = $signed(pv(r, c));
    return m;
  endfunction

  task automatic px_a(input int r, input int c);
    a_iv = 1'b1;
    a_id = img[r][c];
    @(posedge clk); #1;
    if (done2(r, c, 2)) begin
      chk("a_valid", 16'(a_ov), 16'd1);
      chk("a_data", 16'(a_od), 16'(exp_max[((r - 1) / 2) * 3 + (c - 1) / 2]));
      chk("a_last", 16'(a_ol), 16'(r == 5 && c == 5));
    end else begin
      chk("a_idle", 16'(a_ov), 16'd0);
    end
    a_iv = 1'b0;
  endtask

  task automatic frame_a(input bit stall);
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        if (stall && r == 1 && c == 2) begin
          a_nr = 1'b0;
          a_iv = 1'b1;
          a_id = img[1][2];
          for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("stall_ready", 16'(a_or), 16'd0);
            chk("stall_valid", 16'(a_ov), 16'd1);
            chk("stall_data", 16'(a_od), 16'h7);
            chk("stall_last", 16'(a_ol), 16'd0);
          end
          a_nr = 1'b1;
          #1;
          chk("release_ready", 16'(a_or), 16'd1);
        end
        px_a(r, c);
      end
    end
  endtask

  task automatic px_b(input int r, input int c, input logic [7:0] d,
                      input logic [7:0] want, input bit bub);
    int nb;
    nb = bub ? int'($urandom_range(0, 2)) : 0;
    repeat (nb) begin
      b_iv = 1'b0;
      @(posedge clk); #1;
      chk("b_bubble", 16'(b_ov), 16'd0);
      nout  += int'(b_ov);
      nlast += int'(b_ol);
    end
    b_iv = 1'b1;
    b_id = d;
    @(posedge clk); #1;
    chk("b_ready", 16'(b_or), 16'd1);
    nout  += int'(b_ov);
    nlast += int'(b_ol);
    if (done2(r, c, 2)) begin
      chk("b_valid", 16'(b_ov), 16'd1);
      chk("b_data", 16'(b_od), 16'(want));
      chk("b_last", 16'(b_ol), 16'(r == 5 && c == 5));
    end else begin
      chk("b_idle", 16'(b_ov), 16'd0);
    end
    b_iv = 1'b0;
  endtask

  task automatic px_c(input int r, input int c);
    c_iv = 1'b1;
    c_id = pv(r, c);
    @(posedge clk); #1;
    chk("c_ready", 16'(c_or), 16'd1);
    nout += int'(c_ov);
    if (done2(r, c, 1)) begin
      chk("c_valid", 16'(c_ov), 16'd1);
      chk("c_data", 16'(c_od), 16'(maxc(r, c)));
      chk("c_last", 16'(c_ol), 16'(r == 5 && c == 5));
    end else begin
      chk("c_idle", 16'(c_ov), 16'd0);
    end
    c_iv = 1'b0;
  endtask

  initial begin
    a_iv = 1'b0; a_id = '0; a_nr = 1'b1;
    b_iv = 1'b0; b_id = '0; b_nr = 1'b1;
    c_iv = 1'b0; c_id = '0; c_nr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 16'(a_ov), 16'd0);
    chk("rst_data", 16'(a_od), 16'd0);
    chk("rst_last", 16'(a_ol), 16'd0);
    chk("rst_ready", 16'(a_or), 16'd1);
    res = 1'b0;

    frame_a(1'b0);
    frame_a(1'b1);

    for (int k = 0; k < 10; k++) px_a(k / 6, k % 6);
    res = 1'b1;
    #1;
    chk("midrst_valid", 16'(a_ov), 16'd0);
    chk("midrst_data", 16'(a_od), 16'd0);
    chk("midrst_last", 16'(a_ol), 16'd0);
    @(posedge clk); #1;
    res = 1'b0;
    frame_a(1'b0);

    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        px_b(r, c, {4'h8, img[r][c]},
             done2(r, c, 2) ? {4'h8, exp_avg[((r - 1) / 2) * 3 + (c - 1) / 2]} : 8'h00, 1'b0);
    nout  = 0;
    nlast = 0;
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++)
          px_b(r, c, {4'h8, 4'h3}, {4'h8, 4'h3}, 1'b1);
    chk("b_out_count", 16'(nout), 16'd18);
    chk("b_last_count", 16'(nlast), 16'd2);

    nout = 0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        px_c(r, c);
    chk("c_out_count", 16'(nout), 16'd25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pooling_layer_mc.md
Name: pooling_layer_mc

Overview:
Streaming multi-channel 2-D pooling layer for the CNN datapath, sitting between a convolution layer and the next layer.
- Generalises the single-channel, fixed-stride max pooling layer with: NumChannels parallel channels, independent Stride (overlapping windows allowed), max or average mode, downstream backpressure, and an end-of-frame flag.
- Pixels arrive row-major, one pixel position per accepted beat, all channels side by side.

Parameters:
BitSize, 4, signed two's-complement width of each channel sample
N, 2, pooling window edge (window is N x N); N >= 2
ImageWidth, 6, square input image edge; (ImageWidth-N) % Stride == 0 required
Stride, 2, window step in rows and columns; 1 <= Stride <= N
NumChannels, 1, channels processed in parallel (lane k = bits [k*BitSize +: BitSize])
Mode, 0, 0 = max pooling, 1 = average pooling (N must be a power of two when Mode = 1)

Ports:
clk  input  1  clock, all state updates on rising edge
res  input  1  asynchronous active-high reset
in_valid  input  1  in_data holds a valid pixel position
in_data  input  NumChannels*BitSize  one signed sample per channel
out_ready  output  1  block accepts in_data this cycle; transfer = in_valid && out_ready
out_valid  output  1  out_data holds a valid pooled result
out_data  output  NumChannels*BitSize  one signed pooled result per channel
next_ready  input  1  downstream accepts out_data; transfer = out_valid && next_ready
out_last  output  1  qualifies out_data as the final window of the current frame

Behaviour:
- Reset: async on res high. Clears out_valid, out_last, out_data, row/col counters, line buffers and window registers to 0. out_ready = 1 immediately after reset releases. Reset mid-frame discards the partial frame; the next accepted pixel is (0,0).
- Counters: col 0..ImageWidth-1 and row 0..ImageWidth-1 advance only on an input transfer.
  - Col wraps to 0 and increments row.
  - After pixel (ImageWidth-1, ImageWidth-1), both wrap to 0; the next frame starts with no idle cycle.
- Storage: N-1 rows of ImageWidth x NumChannels samples plus an N x N window per channel. Stale data from a previous frame must never enter a result.
- Window completion: accepting pixel (r,c) completes a window iff r >= N-1, c >= N-1, (r-N+1) % Stride == 0 and (c-N+1) % Stride == 0.
  - Output grid is OutW x OutW, with OutW = (ImageWidth-N)/Stride + 1.
- Latency: out_valid rises on the clock edge that accepts the completing pixel, so the result is visible in the following cycle.
  - out_data holds, per channel, the result over rows r-N+1..r and columns c-N+1..c.
- Max mode: signed comparison (4'b1000 = -8 is the minimum).
- Average mode:
  - Sum in BitSize + 2*log2(N) bits, sign-extended.
  - Result = arithmetic right shift by 2*log2(N), i.e. floor division.
  - Truncate to BitSize; this never overflows.
- Output register: single entry.
  - out_valid holds with out_data and out_last stable until next_ready is sampled high.
  - On that edge out_valid clears, unless a new window completes on the same edge, in which case the new result is loaded and out_valid stays 1.
- Backpressure: out_ready = !(out_valid && !next_ready).
  - Input stalls only while a result is pending and refused.
  - Non-completing pixels are also stalled in this state; this keeps flow control simple.
- in_valid low: no state change; counters hold. Bubbles are allowed anywhere in a frame.
- out_last = 1 only with the result completed by pixel (ImageWidth-1, ImageWidth-1); it clears when that result transfers.
- Channels are fully independent; all share one handshake.

Test Plan:
- Max mode, N=2, Stride=2, ImageWidth=6, NumChannels=1, next_ready=1, no bubbles. Rows 0-1 are 7,2,2,-1,2,-1 / -8,-8,-1,7,-1,7. Required: first three outputs 7,7,7; 9 outputs total; out_last only on the 9th.
- Same image, Mode=1. Required: first output floor(-7/4) = -2 (4'b1110); second and third floor(7/4) = 1.
- Stride=1, N=2, ImageWidth=6, pixel value = row*6+col truncated to 4 bits, max mode. Required: 25 outputs; first output 7 (pixel (1,1)); first out_valid one cycle after accepting pixel (1,1).
- Backpressure: hold next_ready=0 for 5 cycles while the first result is pending. Required: out_data/out_valid stable, out_ready=0, counters frozen. Raise next_ready: out_ready returns to 1 and the result sequence is identical to the unstalled run.
- NumChannels=2: ch0 constant 3, ch1 constant -8, average mode, random in_valid bubbles. Required: every output is {ch1=-8, ch0=3}; output count 9 per frame; two back-to-back frames give 18 outputs and 2 out_last pulses.
- Assert res for one cycle after 10 pixels of a frame. Required: out_valid=0 and out_data=0 at once. A full new frame then produces exactly 9 correct outputs with no contribution from the pre-reset pixels.
